// File: rtl/fft_r22sdf_twmul_1024_s3_if.sv
// Twiddle-multiplier bus for one R2^2 SDF stage.
// Groups the sample stream, the external twiddle ROM handshake and the output stream.
//   master : sample source + twiddle ROM (drives in_*, tf_*; observes addr*, out_*)
//   slave  : the multiplier itself (consumes in_*, tf_*; drives addr*, out_*)
// tf_re/tf_im are signed Q1.9 and must be valid one clk after addr/addr_vld.
interface fft_r22sdf_twmul_1024_s3_if #(
  parameter int unsigned DW = 16
);
  logic                 in_vld;
  logic                 in_sof;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic [3:0]           addr;
  logic                 addr_vld;
  logic signed [9:0]    tf_re;
  logic signed [9:0]    tf_im;
  logic                 out_vld;
  logic                 out_sof;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;

  modport master (
    output in_vld, in_sof, in_re, in_im, tf_re, tf_im,
    input  addr, addr_vld, out_vld, out_sof, out_re, out_im
  );

  modport slave (
    input  in_vld, in_sof, in_re, in_im, tf_re, tf_im,
    output addr, addr_vld, out_vld, out_sof, out_re, out_im
  );
endinterface

// File: rtl/fft_r22sdf_twmul_1024_s3.sv
// Twiddle multiplier for stage 3 of a 1024-point R2^2 SDF FFT.
// Walks a 16-entry twiddle ROM (external, one-cycle read latency) in step with the
// sample stream and multiplies each sample by its twiddle, with round-half-up and
// saturation back to DW bits. Fixed latency of 3 clk, one sample per clk, no backpressure.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): in_vld/in_sof/in_re/in_im  sample stream in
//                addr/addr_vld              ROM address out (combinational)
//                tf_re/tf_im                Q1.9 twiddle in, one clk after addr
//                out_vld/out_sof/out_re/out_im twiddled stream out
module fft_r22sdf_twmul_1024_s3 #(
  parameter int unsigned DW = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  fft_r22sdf_twmul_1024_s3_if.slave bus
);

  localparam int unsigned TW   = 10;          // twiddle width (Q1.9)
  localparam int unsigned PW   = DW + TW;     // full product width
  localparam int unsigned SW   = DW + TW + 1; // sum width, cannot overflow
  localparam int unsigned Frac = 9;           // twiddle fraction bits

  localparam logic signed [SW-1:0] RndBias = SW'(256);
  localparam logic signed [SW-1:0] SatMax  = {{(TW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [SW-1:0] SatMin  = {{(TW + 2){1'b1}}, {(DW - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Twiddle index. A valid sof sample uses address 0, so the next one is 1.
  // ---------------------------------------------------------------------------
  logic [3:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (bus.in_vld) begin
      idx_d = bus.in_sof ? 4'd1 : idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 4'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign bus.addr     = bus.in_sof ? 4'd0 : idx_q;
  assign bus.addr_vld = bus.in_vld;

  // ---------------------------------------------------------------------------
  // Stage 1: hold the sample for one cycle so it meets the ROM read data.
  // ---------------------------------------------------------------------------
  logic                 s1_vld_q, s1_sof_q;
  logic signed [DW-1:0] s1_re_q, s1_im_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
    end else begin
      s1_vld_q <= bus.in_vld;
      s1_sof_q <= bus.in_vld & bus.in_sof;
      if (bus.in_vld) begin
        s1_re_q <= bus.in_re;
        s1_im_q <= bus.in_im;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: four full-width partial products.
  // ---------------------------------------------------------------------------
  logic                 s2_vld_q, s2_sof_q;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;

  always_comb begin
    p_rr_d = PW'(s1_re_q) * PW'(bus.tf_re);
    p_ii_d = PW'(s1_im_q) * PW'(bus.tf_im);
    p_ri_d = PW'(s1_re_q) * PW'(bus.tf_im);
    p_ir_d = PW'(s1_im_q) * PW'(bus.tf_re);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      s2_sof_q <= 1'b0;
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ri_q   <= '0;
      p_ir_q   <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_sof_q <= s1_vld_q & s1_sof_q;
      if (s1_vld_q) begin
        p_rr_q <= p_rr_d;
        p_ii_q <= p_ii_d;
        p_ri_q <= p_ri_d;
        p_ir_q <= p_ir_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: combine, round half up, saturate.
  // ---------------------------------------------------------------------------
  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    if (v > SatMax) begin
      c = SatMax;
    end else if (v < SatMin) begin
      c = SatMin;
    end else begin
      c = v;
    end
    return c[DW-1:0];
  endfunction

  logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;

  always_comb begin
    sum_re = SW'(p_rr_q) - SW'(p_ii_q);
    sum_im = SW'(p_ri_q) + SW'(p_ir_q);
    // Bias of half an LSB then floor shift gives round-half-up.
    rnd_re = (sum_re + RndBias) >>> Frac;
    rnd_im = (sum_im + RndBias) >>> Frac;
  end

  logic                 out_vld_q, out_sof_q;
  logic signed [DW-1:0] out_re_q, out_im_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_sof_q <= 1'b0;
      out_re_q  <= '0;
      out_im_q  <= '0;
    end else begin
      out_vld_q <= s2_vld_q;
      out_sof_q <= s2_vld_q & s2_sof_q;
      // Data holds its last value through gaps.
      if (s2_vld_q) begin
        out_re_q <= sat(rnd_re);
        out_im_q <= sat(rnd_im);
      end
    end
  end

  assign bus.out_vld = out_vld_q;
  assign bus.out_sof = out_sof_q;
  assign bus.out_re  = out_re_q;
  assign bus.out_im  = out_im_q;

endmodule

// File: tb/tb_fft_r22sdf_twmul_1024_s3.sv
// Self-checking bench for fft_r22sdf_twmul_1024_s3: behavioural complex-multiply model
// with a Q1.9 twiddle ROM, an expectation queue stamped with due cycle, and directed
// plus random stimulus.
module tb_fft_r22sdf_twmul_1024_s3;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_r22sdf_twmul_1024_s3_if #(.DW(DW)) bus ();

  fft_r22sdf_twmul_1024_s3 #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Twiddle table: 16-point R2^2 pattern, exponent = (n%4) * {0,2,1,3}[n/4] of W16.
  function automatic int tw_exp(input int a);
    int g, m, mul;
    g = a / 4;
    m = a % 4;
    case (g)
      0:       mul = 0;
      1:       mul = 2;
      2:       mul = 1;
      default: mul = 3;
    endcase
    return m * mul;
  endfunction

  // round(512*cos(2*pi*e/16)), clipped to 511
  function automatic int tw_re(input int a);
    case (tw_exp(a))
      0: return 511;   1: return 473;   2: return 362;   3: return 196;
      4: return 0;     5: return -196;  6: return -362;  7: return -473;
      8: return -512;  default: return -473;
    endcase
  endfunction

  // round(-512*sin(2*pi*e/16))
  function automatic int tw_im(input int a);
    case (tw_exp(a))
      0: return 0;     1: return -196;  2: return -362;  3: return -473;
      4: return -512;  5: return -473;  6: return -362;  7: return -196;
      8: return 0;     default: return 196;
    endcase
  endfunction

  function automatic int sat_rnd(input longint v);
    longint r;
    r = (v + 256) >>> 9;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic model(input int re, input int im, input int a, output int ore, output int oim);
    longint tr, ti;
    tr = tw_re(a);
    ti = tw_im(a);
    ore = sat_rnd(longint'(re) * tr - longint'(im) * ti);
    oim = sat_rnd(longint'(re) * ti + longint'(im) * tr);
  endtask

  // External ROM with one cycle read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tf_re <= '0;
      bus.tf_im <= '0;
    end else if (bus.addr_vld) begin
      bus.tf_re <= 10'(tw_re(int'(bus.addr)));
      bus.tf_im <= 10'(tw_im(int'(bus.addr)));
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int due;
    int re;
    int im;
    bit sof;
  } exp_t;

  exp_t q[$];
  exp_t ec;
  int   cyc = 0;
  int   m_idx = 0;
  int   last_re = 0;
  int   last_im = 0;
  bit   chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output compare: every cycle out of reset, either the due sample or idle/hold.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        ec = q.pop_front();
        chk("out_late", 0, 1);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        ec = q.pop_front();
        chk("out_vld", bus.out_vld, 1);
        chk("out_sof", bus.out_sof, ec.sof);
        chk("out_re", bus.out_re, ec.re);
        chk("out_im", bus.out_im, ec.im);
        last_re = ec.re;
        last_im = ec.im;
      end else begin
        chk("out_vld_idle", bus.out_vld, 0);
        chk("out_sof_idle", bus.out_sof, 0);
        chk("out_re_hold", bus.out_re, last_re);
        chk("out_im_hold", bus.out_im, last_im);
      end
    end
  end

  // One clock of stimulus; exp_addr < 0 means check against the model only.
  task automatic drive(input bit vld, input bit sof, input int re, input int im,
                       input int exp_addr);
    int a;
    exp_t e;
    a = 0;
    @(posedge clk);
    #1;
    bus.in_vld = vld;
    bus.in_sof = sof;
    bus.in_re  = DW'(re);
    bus.in_im  = DW'(im);
    if (vld) begin
      a = sof ? 0 : m_idx;
      m_idx = sof ? 1 : (m_idx + 1) % 16;
      model(re, im, a, e.re, e.im);
      e.sof = sof;
      e.due = cyc + 3;
      q.push_back(e);
    end
    @(negedge clk);
    if (vld) begin
      chk("addr_vld", bus.addr_vld, 1);
      chk("addr", bus.addr, a);
      if (exp_addr >= 0) chk("addr_lit", bus.addr, exp_addr);
    end else begin
      chk("addr_vld_low", bus.addr_vld, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, -1);
  endtask

  function automatic int rnd_sample();
    logic signed [15:0] t;
    case ($urandom_range(0, 9))
      0: return -32768;
      1: return 32767;
      2: return 0;
      default: begin
        t = 16'($urandom);
        return int'(t);
      end
    endcase
  endfunction

  initial begin
    int ore, oim;
    bit v, s;
    bus.in_vld = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_re  = '0;
    bus.in_im  = '0;

    // Pin the model against hand-computed values.
    model(1000, 0, 0, ore, oim);
    chk("pin_idx0_re", ore, 998);
    chk("pin_idx0_im", oim, 0);
    model(1000, 0, 5, ore, oim);
    chk("pin_idx5_re", ore, 707);
    chk("pin_idx5_im", oim, -707);
    model(1000, 0, 6, ore, oim);
    chk("pin_idx6_re", ore, 0);
    chk("pin_idx6_im", oim, -1000);
    model(-32768, 0, 6, ore, oim);
    chk("pin_sat1_re", ore, 0);
    chk("pin_sat1_im", oim, 32767);
    model(32767, 32767, 6, ore, oim);
    chk("pin_sat2_re", ore, 32767);
    chk("pin_sat2_im", oim, -32767);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_sof", bus.out_sof, 0);
    chk("rst_out_re", bus.out_re, 0);
    chk("rst_out_im", bus.out_im, 0);
    chk("rst_addr", bus.addr, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    idle(2);

    // 16 consecutive samples, sof on the first.
    for (int i = 0; i < 16; i++) drive(1'b1, i == 0, 1000, 0, i);
    idle(4);

    // Saturation at index 6.
    for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 0, 0, i);
    drive(1'b1, 1'b0, -32768, 0, 6);
    for (int i = 0; i < 6; i++) drive(1'b1, i == 0, 0, 0, i);
    drive(1'b1, 1'b0, 32767, 32767, 6);
    idle(4);

    // 3-clk gap between indices 3 and 4.
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 100 * i + 5, -37 * i, i);
    idle(3);
    drive(1'b1, 1'b0, 1234, -4321, 4);
    idle(4);

    // Wrap: 20 samples, sof only on the first.
    for (int i = 0; i < 20; i++) drive(1'b1, i == 0, 300 + i, 50 - i, i % 16);
    // Resync: sof on sample 9 of a block.
    for (int i = 0; i < 9; i++) drive(1'b1, i == 0, 777, -777, i);
    drive(1'b1, 1'b1, -555, 222, 0);
    drive(1'b1, 1'b0, 999, 999, 1);
    idle(4);

    // Reset mid-stream discards in-flight samples.
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 2000, 1500, i);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_sof = 1'b0;
    q.delete();
    m_idx = 0;
    last_re = 0;
    last_im = 0;
    @(negedge clk);
    chk("midrst_out_vld", bus.out_vld, 0);
    chk("midrst_out_re", bus.out_re, 0);
    chk("midrst_out_im", bus.out_im, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_addr", bus.addr, 0);
    idle(6);
    drive(1'b1, 1'b0, 1000, 0, 0);
    idle(4);

    // Random stream with gaps and stray sof.
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 19) == 0);
      drive(v, s, rnd_sample(), rnd_sample(), -1);
    end
    idle(6);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
